// File: rtl/led_cmd_if.sv
// Command channel for the LED flash controller: a valid/ready handshake
// carrying the target channel, pattern mode, half-period and burst count.
`timescale 1ns/1ps
interface led_cmd_if;
    logic       Cmd_Valid;
    logic       Cmd_Ready;
    logic [1:0] Cmd_Ch;
    logic [1:0] Cmd_Mode;
    logic [3:0] Cmd_Half;
    logic [3:0] Cmd_Count;

    modport master (
        output Cmd_Valid, Cmd_Ch, Cmd_Mode, Cmd_Half, Cmd_Count,
        input  Cmd_Ready
    );

    modport slave (
        input  Cmd_Valid, Cmd_Ch, Cmd_Mode, Cmd_Half, Cmd_Count,
        output Cmd_Ready
    );
endinterface

// File: rtl/led_flash_ctrl.sv
// Four-channel LED flash controller: off / steady / blink / counted burst,
// all channels paced by one shared free-running 50 ms tick.
`timescale 1ns/1ps
module led_flash_ctrl #(
    parameter logic [21:0] T50MS = 22'd2_499_999
) (
    input  logic       CLK,
    input  logic       RSTn,
    led_cmd_if.slave   cmd,
    output logic [3:0] LED_Out,
    output logic [3:0] Busy,
    output logic [3:0] Done
);

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_ON    = 2'd1,
        ST_BLINK = 2'd2,
        ST_BURST = 2'd3
    } state_t;

    localparam logic [1:0] MODE_OFF   = 2'd0;
    localparam logic [1:0] MODE_ON    = 2'd1;
    localparam logic [1:0] MODE_BLINK = 2'd2;
    localparam logic [1:0] MODE_BURST = 2'd3;

    state_t      state_r    [4];
    logic [3:0]  half_cnt_r [4];
    logic [3:0]  half_r     [4];
    logic [3:0]  rem_r      [4];
    logic [3:0]  led_r;
    logic [3:0]  busy_r;
    logic [3:0]  done_r;
    logic [21:0] presc_r;
    logic        ready_r;

    logic        tick_s;
    logic        accept_s;
    logic [3:0]  half_eff_s;

    assign tick_s     = (presc_r == T50MS);
    assign accept_s   = cmd.Cmd_Valid && ready_r;
    assign half_eff_s = (cmd.Cmd_Half == 4'd0) ? 4'd1 : cmd.Cmd_Half;

    assign cmd.Cmd_Ready = ready_r;
    assign LED_Out       = led_r;
    assign Busy          = busy_r;
    assign Done          = done_r;

    // Shared tick prescaler, free-running and untouched by commands.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            presc_r <= 22'd0;
        end else if (tick_s) begin
            presc_r <= 22'd0;
        end else begin
            presc_r <= presc_r + 22'd1;
        end
    end

    // Ready drops for the single cycle after each accept.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            ready_r <= 1'b0;
        end else begin
            ready_r <= !accept_s;
        end
    end

    // Per-channel pattern FSMs; a command to a channel pre-empts its tick.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            for (int c = 0; c < 4; c++) begin
                state_r[c]    <= ST_OFF;
                half_cnt_r[c] <= 4'd0;
                half_r[c]     <= 4'd1;
                rem_r[c]      <= 4'd0;
            end
            led_r  <= 4'b0000;
            busy_r <= 4'b0000;
            done_r <= 4'b0000;
        end else begin
            for (int c = 0; c < 4; c++) begin
                done_r[c] <= 1'b0;
                if (accept_s && (cmd.Cmd_Ch == 2'(c))) begin
                    half_cnt_r[c] <= 4'd0;
                    half_r[c]     <= half_eff_s;
                    case (cmd.Cmd_Mode)
                        MODE_OFF: begin
                            state_r[c] <= ST_OFF;
                            led_r[c]   <= 1'b0;
                            busy_r[c]  <= 1'b0;
                        end
                        MODE_ON: begin
                            state_r[c] <= ST_ON;
                            led_r[c]   <= 1'b1;
                            busy_r[c]  <= 1'b0;
                        end
                        MODE_BLINK: begin
                            state_r[c] <= ST_BLINK;
                            led_r[c]   <= 1'b1;
                            busy_r[c]  <= 1'b1;
                        end
                        MODE_BURST: begin
                            if (cmd.Cmd_Count != 4'd0) begin
                                state_r[c] <= ST_BURST;
                                led_r[c]   <= 1'b1;
                                busy_r[c]  <= 1'b1;
                                rem_r[c]   <= cmd.Cmd_Count;
                            end else begin
                                state_r[c] <= ST_OFF;
                                led_r[c]   <= 1'b0;
                                busy_r[c]  <= 1'b0;
                                done_r[c]  <= 1'b1;
                            end
                        end
                        default: begin
                            state_r[c] <= ST_OFF;
                            led_r[c]   <= 1'b0;
                            busy_r[c]  <= 1'b0;
                        end
                    endcase
                end else if (tick_s && ((state_r[c] == ST_BLINK) || (state_r[c] == ST_BURST))) begin
                    if (half_cnt_r[c] == (half_r[c] - 4'd1)) begin
                        half_cnt_r[c] <= 4'd0;
                        if (state_r[c] == ST_BLINK) begin
                            led_r[c] <= ~led_r[c];
                        end else if (led_r[c]) begin
                            led_r[c] <= 1'b0;
                            rem_r[c] <= rem_r[c] - 4'd1;
                        end else if (rem_r[c] == 4'd0) begin
                            // Last off-phase has expired: burst finished.
                            state_r[c] <= ST_OFF;
                            busy_r[c]  <= 1'b0;
                            done_r[c]  <= 1'b1;
                        end else begin
                            led_r[c] <= 1'b1;
                        end
                    end else begin
                        half_cnt_r[c] <= half_cnt_r[c] + 4'd1;
                    end
                end else begin
                    half_cnt_r[c] <= half_cnt_r[c];
                end
            end
        end
    end

endmodule

// File: tb/tb_led_flash_ctrl.sv
// Self-checking bench for led_flash_ctrl with a 5-clock tick; per-channel
// expected LED/Busy/Done sequences are queued at each accept and popped per cycle.
`timescale 1ns/1ps
module tb_led_flash_ctrl;

    logic       CLK;
    logic       RSTn;
    logic [3:0] LED_Out;
    logic [3:0] Busy;
    logic [3:0] Done;

    led_cmd_if cmd ();

    led_flash_ctrl #(.T50MS(22'd4)) dut (
        .CLK     (CLK),
        .RSTn    (RSTn),
        .cmd     (cmd.slave),
        .LED_Out (LED_Out),
        .Busy    (Busy),
        .Done    (Done)
    );

    typedef struct {
        logic led;
        logic busy;
        logic done;
    } exp_t;

    exp_t sb_q [4][$];
    exp_t mon_e;
    int   checks_cnt   = 0;
    int   failures_cnt = 0;
    int   tb_presc;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, required finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            failures_cnt++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Independent view of the prescaler phase, used to predict tick edges.
    always @(posedge CLK or negedge RSTn) begin
        if (!RSTn) tb_presc <= 0;
        else       tb_presc <= (tb_presc == 4) ? 0 : tb_presc + 1;
    end

    // Expected outputs k edges after an accept whose edge saw prescaler value pa.
    function automatic exp_t model(input logic [1:0] mode, input int pa, input int half,
                                   input int cnt, input int k);
        int   d, n, h;
        exp_t e;
        d = (pa == 4) ? 5 : (4 - pa);
        n = (k >= d) ? ((k - d) / 5 + 1) : 0;
        h = n / half;
        e.led = 1'b0; e.busy = 1'b0; e.done = 1'b0;
        case (mode)
            2'd0: e.led = 1'b0;
            2'd1: e.led = 1'b1;
            2'd2: begin e.led = (h % 2 == 0); e.busy = 1'b1; end
            default: begin
                if (cnt == 0) begin
                    e.done = (k == 0);
                end else if (h < 2 * cnt) begin
                    e.led  = (h % 2 == 0);
                    e.busy = 1'b1;
                end else begin
                    e.done = (n == 2 * cnt * half) && (k >= d) && ((k - d) % 5 == 0);
                end
            end
        endcase
        return e;
    endfunction

    // Scoreboard monitor: one expected entry per channel per cycle.
    always @(negedge CLK) begin
        for (int c = 0; c < 4; c++) begin
            if (sb_q[c].size() > 0) begin
                mon_e = sb_q[c].pop_front();
                check($sformatf("sb_ch%0d", c), {29'd0, LED_Out[c], Busy[c], Done[c]},
                      {29'd0, mon_e.led, mon_e.busy, mon_e.done});
            end
        end
    end

    task automatic wait_presc(input int v);
        int guard = 0;
        @(negedge CLK);
        while ((tb_presc != v) && (guard < 10)) begin
            @(negedge CLK);
            guard++;
        end
        if (tb_presc != v) check("presc_align", 32'(tb_presc), 32'(v));
    endtask

    // Drive a command at the current negedge and hold it until accepted.
    task automatic send(input logic [1:0] ch, input logic [1:0] mode, input logic [3:0] half,
                        input logic [3:0] count, input int horizon);
        int guard = 0;
        int pa;
        int heff;
        cmd.Cmd_Ch    = ch;
        cmd.Cmd_Mode  = mode;
        cmd.Cmd_Half  = half;
        cmd.Cmd_Count = count;
        cmd.Cmd_Valid = 1'b1;
        while (!cmd.Cmd_Ready && (guard < 20)) begin
            @(negedge CLK);
            guard++;
        end
        if (!cmd.Cmd_Ready) begin
            check("ready_timeout", 32'd0, 32'd1);
            cmd.Cmd_Valid = 1'b0;
            return;
        end
        pa   = tb_presc;
        heff = (half == 4'd0) ? 1 : int'(half);
        @(posedge CLK);
        sb_q[ch].delete();
        for (int k = 0; k < horizon; k++)
            sb_q[ch].push_back(model(mode, pa, heff, int'(count), k));
        @(negedge CLK);
        cmd.Cmd_Valid = 1'b0;
    endtask

    initial begin
        int  acc;
        logic rdy;
        RSTn          = 1'b0;
        cmd.Cmd_Valid = 1'b0;
        cmd.Cmd_Ch    = 2'd0;
        cmd.Cmd_Mode  = 2'd0;
        cmd.Cmd_Half  = 4'd0;
        cmd.Cmd_Count = 4'd0;

        // Reset values and Ready rising one edge after release.
        repeat (3) @(negedge CLK);
        check("rst_led",   {28'd0, LED_Out}, 32'd0);
        check("rst_busy",  {28'd0, Busy},    32'd0);
        check("rst_done",  {28'd0, Done},    32'd0);
        check("rst_ready", {31'd0, cmd.Cmd_Ready}, 32'd0);
        RSTn = 1'b1;
        #1;
        check("ready_pre_edge", {31'd0, cmd.Cmd_Ready}, 32'd0);
        @(negedge CLK);
        check("ready_post_edge", {31'd0, cmd.Cmd_Ready}, 32'd1);

        // Handshake pacing: Valid held 6 cycles, channel changes every cycle.
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            cmd.Cmd_Ch    = 2'(i);
            cmd.Cmd_Mode  = 2'd1;
            cmd.Cmd_Valid = 1'b1;
            rdy = cmd.Cmd_Ready;
            check($sformatf("pace_rdy%0d", i), {31'd0, rdy}, {31'd0, (i % 2 == 0)});
            if (rdy) acc++;
            @(negedge CLK);
        end
        cmd.Cmd_Valid = 1'b0;
        check("pace_acc", 32'(acc), 32'd3);
        check("pace_led", {28'd0, LED_Out}, 32'h5);
        send(2'd0, 2'd0, 4'd0, 4'd0, 4);
        send(2'd2, 2'd0, 4'd0, 4'd0, 4);
        repeat (4) @(negedge CLK);

        // BLINK on ch1, Half=2.
        wait_presc(0);
        send(2'd1, 2'd2, 4'd2, 4'd0, 50);
        repeat (50) @(negedge CLK);

        // BURST on ch2, Half=1, Count=3.
        wait_presc(0);
        send(2'd2, 2'd3, 4'd1, 4'd3, 40);
        repeat (40) @(negedge CLK);

        // Mid-burst abort on ch0, then zero-count burst.
        wait_presc(0);
        send(2'd0, 2'd3, 4'd1, 4'd5, 60);
        repeat (20) @(negedge CLK);
        send(2'd0, 2'd0, 4'd0, 4'd0, 30);
        repeat (30) @(negedge CLK);
        send(2'd0, 2'd3, 4'd1, 4'd0, 10);
        repeat (10) @(negedge CLK);

        // Tick collision: ch0 blinks with Half=0 (acts as 1), ON to ch3 on a tick.
        wait_presc(0);
        send(2'd0, 2'd2, 4'd0, 4'd0, 60);
        wait_presc(4);
        send(2'd3, 2'd1, 4'd0, 4'd0, 10);
        check("coll_led",  {30'd0, LED_Out[3], LED_Out[0]}, 32'h2);
        check("coll_busy", {30'd0, Busy[3], Busy[0]},       32'h1);
        repeat (7) @(negedge CLK);

        // Asynchronous reset mid-blink.
        for (int c = 0; c < 4; c++) sb_q[c].delete();
        check("pre_rst_led3", {31'd0, LED_Out[3]}, 32'd1);
        check("pre_rst_busy0", {31'd0, Busy[0]}, 32'd1);
        #2 RSTn = 1'b0;
        #1;
        check("async_rst_led",   {28'd0, LED_Out}, 32'd0);
        check("async_rst_busy",  {28'd0, Busy},    32'd0);
        check("async_rst_ready", {31'd0, cmd.Cmd_Ready}, 32'd0);
        repeat (2) @(negedge CLK);
        check("async_rst_done", {28'd0, Done}, 32'd0);
        RSTn = 1'b1;
        repeat (2) @(negedge CLK);

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, failures_cnt);
        $finish;
    end

endmodule

// File: doc/led_flash_ctrl.md
# led_flash_ctrl

Four-channel LED flash controller that sequences a bank of LED outputs through off, steady-on, continuous-blink and counted-burst patterns. A single shared 50 ms tick prescaler drives all channels. Commands arrive over a valid/ready handshake from the board-level control logic. The block drives the LED pins directly.

## Interface
- T50MS, 22'd2_499_999: prescaler terminal count; one tick every T50MS+1 clocks (50 ms at 50 MHz).
- CLK  input  1  system clock, all logic on rising edge.
- RSTn  input  1  asynchronous active-low reset.
- Cmd_Valid  input  1  command present.
- Cmd_Ready  output  1  block can accept a command this cycle.
- Cmd_Ch  input  2  target channel 0..3.
- Cmd_Mode  input  2  0 OFF, 1 ON, 2 BLINK, 3 BURST.
- Cmd_Half  input  4  half-period in ticks; 0 is treated as 1.
- Cmd_Count  input  4  BURST on-pulse count; ignored for other modes.
- LED_Out  output  4  LED drive, 1 = lit.
- Busy  output  4  channel is in BLINK or BURST.
- Done  output  4  one-cycle pulse when a BURST completes normally.

## Operation
- Prescaler: 22-bit free-running counter 0..T50MS with wrap to 0; Tick is asserted in the cycle where count == T50MS. The prescaler is never reset by commands.
- Handshake: a command is accepted on a rising edge with Cmd_Valid && Cmd_Ready. Cmd_Ready deasserts for exactly the one cycle following each accept, then reasserts. Cmd_Valid while Cmd_Ready is low is ignored. The source holds its fields until accepted.
- Per-channel state: ST_OFF, ST_ON, ST_BLINK, ST_BURST. Each channel has a 4-bit half-period counter, a 4-bit half-period register, a 4-bit remaining-pulse counter, and a phase bit that is the LED level.
- On accept for channel c, regardless of c's current state (including mid-burst abort, which produces no Done):
  - OFF -> ST_OFF, LED 0.
  - ON -> ST_ON, LED 1.
  - BLINK -> ST_BLINK, LED 1, half counter 0.
  - BURST with Count != 0 -> ST_BURST, LED 1, half counter 0, remaining = Count.
  - BURST with Count == 0 -> ST_OFF, LED 0, Done[c] pulses on the cycle after accept.
- BLINK/BURST on Tick: if half counter == Half-1, then toggle LED and clear the half counter; otherwise increment the half counter.
- BURST: on each 1->0 toggle, decrement remaining. When remaining has reached 0 and the following off-phase expires (that is, the point where the LED would return to 1), go to ST_OFF with LED 0 and pulse Done[c] for one cycle.
- Simultaneous accept and Tick on the same channel: the command wins and the Tick is ignored for that channel. Other channels process the Tick normally.
- Busy[c] = state is ST_BLINK or ST_BURST.

## Timing
- Reset values: LED_Out 4'b0000, Busy 0, Done 0, Cmd_Ready 0, all states ST_OFF, prescaler 0. Cmd_Ready rises on the first CLK edge after RSTn deasserts.
- An assertion of RSTn mid-operation immediately forces all reset values asynchronously. No Done is generated.
- Command latency: LED_Out and Busy reflect the new mode directly after the accepting edge, with 1 cycle of latency.
- Because the prescaler free-runs, the first half-period after a load is between Half-1 and Half ticks plus a partial tick. Every later half-period is exactly Half ticks.
- Done is registered and is never asserted for more than one cycle per burst.
- Maximum command rate is one command every 2 cycles.

## Test plan
- Reset: hold RSTn low, then release → all outputs 0. Cmd_Ready goes 1 one cycle later. Asserting RSTn mid-BLINK clears LED_Out at once without waiting for a clock edge.
- Handshake pacing: hold Cmd_Valid high for 6 cycles with changing Cmd_Ch → exactly 3 accepts (every other cycle). Cmd_Ready pattern is 1,0,1,0,1,0.
- BLINK with T50MS=4 (tick every 5 clocks), Ch1, Half=2 → LED_Out[1]=1 after accept. After the first partial period, it toggles every 10 clocks steadily and Busy[1]=1.
- BURST with T50MS=4, Ch2, Half=1, Count=3 → three high pulses of 5 clocks with 5-clock gaps. Then LED_Out[2]=0, Busy[2]=0, and Done[2] pulses exactly once.
- Abort/zero-count: issue BURST Count=5 on Ch0, then OFF after 2 pulses → LED 0 and no Done. A separate BURST with Count=0 → Done[0] pulses the cycle after accept and the LED stays 0.
- Tick collision: accept ON for Ch3 in the exact cycle Tick asserts while Ch0 blinks with Half=1 → Ch3 goes steady 1, and Ch0 still toggles on that Tick.
